// File: rtl/gt_compare_sequencer_if.sv
// Request/result handshake bundle for the multi-cycle magnitude comparator.
// The master side issues operands and consumes the one-hot result.
interface gt_compare_sequencer_if #(
   parameter int WIDTH = 32
);
   localparam int SLICE_W = $clog2(WIDTH / 2 + 1);

   logic               start_valid;
   logic               start_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               is_signed;
   logic               res_valid;
   logic               res_ready;
   logic               gt;
   logic               eq;
   logic               lt;
   logic [SLICE_W-1:0] slices;
   logic               busy;

   modport master (
      output start_valid, a, b, is_signed, res_ready,
      input  start_ready, res_valid, gt, eq, lt, slices, busy
   );

   modport slave (
      input  start_valid, a, b, is_signed, res_ready,
      output start_ready, res_valid, gt, eq, lt, slices, busy
   );
endinterface

// File: rtl/gt_compare_sequencer.sv
// Sequential magnitude comparator: walks 2-bit slices MSB-first and stops at
// the first slice that differs, returning a one-hot gt/eq/lt result.
module gt_compare_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gt_compare_sequencer_if.slave bus
);
   localparam int N       = WIDTH / 2;
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam int SLICE_W = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t             state_q,  state_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   logic               signed_q, signed_d;
   logic               gt_q,     gt_d;
   logic               eq_q,     eq_d;
   logic               lt_q,     lt_d;
   logic [SLICE_W-1:0] slices_q, slices_d;

   // Same 2-bit greater-than primitive used by the comparator datapath.
   function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
      return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
   endfunction

   logic [1:0] a_sl [N];
   logic [1:0] b_sl [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_q[2*gi+1 : 2*gi];
      assign b_sl[gi] = b_q[2*gi+1 : 2*gi];
   end

   logic       top_slice;
   logic       flip;
   logic [1:0] ap;
   logic [1:0] bp;
   logic       slice_gt;
   logic       slice_lt;

   // Flipping the sign bits maps two's complement onto offset binary, so the
   // top slice can then be compared unsigned like every other slice.
   assign top_slice = (idx_q == IDX_W'(N - 1));
   assign flip      = signed_q & top_slice;
   assign ap        = {a_sl[idx_q][1] ^ flip, a_sl[idx_q][0]};
   assign bp        = {b_sl[idx_q][1] ^ flip, b_sl[idx_q][0]};
   assign slice_gt  = gt2(ap, bp);
   assign slice_lt  = gt2(bp, ap);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      signed_d = signed_q;
      gt_d     = gt_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      slices_d = slices_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               a_d      = bus.a;
               b_d      = bus.b;
               signed_d = bus.is_signed;
               idx_d    = IDX_W'(N - 1);
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               lt_d     = 1'b0;
               slices_d = '0;
               state_d  = S_COMPARE;
            end
         end

         S_COMPARE: begin
            slices_d = slices_q + SLICE_W'(1);
            if (slice_gt) begin
               gt_d    = 1'b1;
               state_d = S_DONE;
            end else if (slice_lt) begin
               lt_d    = 1'b1;
               state_d = S_DONE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end

         S_DONE: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
         slices_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         signed_q <= signed_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
         slices_q <= slices_d;
      end
   end

   assign bus.start_ready = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.res_valid   = (state_q == S_DONE);
   assign bus.gt          = gt_q;
   assign bus.eq          = eq_q;
   assign bus.lt          = lt_q;
   assign bus.slices      = slices_q;

   a_onehot_result : assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.res_valid |-> $onehot({bus.gt, bus.eq, bus.lt})
   );
endmodule

// File: tb/tb_gt_compare_sequencer.sv
// Directed bench for gt_compare_sequencer at WIDTH=32: early exit, full-length,
// low-slice sweep, signed compares, backpressure and asynchronous reset.
module tb_gt_compare_sequencer;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   gt_compare_sequencer_if #(.WIDTH(32)) bus_if ();

   gt_compare_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one request, measures accept-to-res_valid latency and consumes the result.
   task automatic do_cmp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sg, input logic [2:0] exp_res, input int exp_sl);
      int cyc;
      @(negedge clk);
      check_val({tag, "_start_ready"}, 32'(bus_if.start_ready), 32'd1);
      bus_if.a           = av;
      bus_if.b           = bv;
      bus_if.is_signed   = sg;
      bus_if.start_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start_valid = 1'b0;
      bus_if.a           = ~av;
      bus_if.b           = ~bv;
      bus_if.is_signed   = ~sg;
      cyc = 0;
      while (!bus_if.res_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val({tag, "_latency"}, 32'(cyc), 32'(exp_sl));
      check_val({tag, "_result"}, 32'({bus_if.gt, bus_if.eq, bus_if.lt}), 32'(exp_res));
      check_val({tag, "_slices"}, 32'(bus_if.slices), 32'(exp_sl));
      $display("txn %s a=%08h b=%08h s=%0d -> gt=%0d eq=%0d lt=%0d slices=%0d lat=%0d",
               tag, av, bv, sg, bus_if.gt, bus_if.eq, bus_if.lt, bus_if.slices, cyc);
      bus_if.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.res_ready = 1'b0;
      check_val({tag, "_drop_valid"}, 32'(bus_if.res_valid), 32'd0);
      check_val({tag, "_ready_back"}, 32'(bus_if.start_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      logic [2:0] er;
      n_checks = 0;
      n_fail   = 0;
      rst_n              = 1'b0;
      bus_if.start_valid = 1'b0;
      bus_if.a           = '0;
      bus_if.b           = '0;
      bus_if.is_signed   = 1'b0;
      bus_if.res_ready   = 1'b0;

      #2;
      check_val("rst_start_ready", 32'(bus_if.start_ready), 32'd1);
      check_val("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
      check_val("rst_busy", 32'(bus_if.busy), 32'd0);
      check_val("rst_flags", 32'({bus_if.gt, bus_if.eq, bus_if.lt}), 32'd0);
      check_val("rst_slices", 32'(bus_if.slices), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      do_cmp("early_gt", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 3'b100, 1);
      do_cmp("full_eq", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 3'b010, 16);
      do_cmp("full_lt", 32'h0000_0001, 32'h0000_0002, 1'b0, 3'b001, 16);

      for (int x = 0; x < 4; x++) begin
         for (int y = 0; y < 4; y++) begin
            er = (x > y) ? 3'b100 : ((x == y) ? 3'b010 : 3'b001);
            do_cmp($sformatf("sweep_%0d_%0d", x, y), 32'hFFFF_FFFC | 32'(x),
                   32'hFFFF_FFFC | 32'(y), 1'b0, er, 16);
         end
      end

      do_cmp("signed_neg1_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 1);
      do_cmp("unsigned_max_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1);
      do_cmp("signed_min_vs_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 1);

      // Backpressure: result held while res_ready stays low.
      @(negedge clk);
      bus_if.a           = 32'hFFFF_FFFF;
      bus_if.b           = 32'h7FFF_FFFF;
      bus_if.is_signed   = 1'b0;
      bus_if.start_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start_valid = 1'b0;
      cyc = 0;
      while (!bus_if.res_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val("bp_latency", 32'(cyc), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus_if.start_valid = 1'b1;
         bus_if.a           = 32'h0;
         bus_if.b           = 32'h1;
         check_val("bp_start_ready", 32'(bus_if.start_ready), 32'd0);
         check_val("bp_res_valid", 32'(bus_if.res_valid), 32'd1);
         check_val("bp_result", 32'({bus_if.gt, bus_if.eq, bus_if.lt}), 32'd4);
         check_val("bp_slices", 32'(bus_if.slices), 32'd1);
      end
      bus_if.start_valid = 1'b0;
      bus_if.res_ready   = 1'b1;
      @(posedge clk);
      #1;
      bus_if.res_ready = 1'b0;
      check_val("bp_ready_back", 32'(bus_if.start_ready), 32'd1);
      check_val("bp_not_busy", 32'(bus_if.busy), 32'd0);
      $display("txn backpressure held 5 cycles, result gt with slices=1");
      do_cmp("after_bp", 32'h0000_0001, 32'h0000_0002, 1'b0, 3'b001, 16);

      // Asynchronous reset in the middle of a long compare.
      @(negedge clk);
      bus_if.a           = 32'h1234_5678;
      bus_if.b           = 32'h1234_5678;
      bus_if.is_signed   = 1'b0;
      bus_if.start_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("mid_busy_before", 32'(bus_if.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_res_valid", 32'(bus_if.res_valid), 32'd0);
      check_val("arst_busy", 32'(bus_if.busy), 32'd0);
      check_val("arst_start_ready", 32'(bus_if.start_ready), 32'd1);
      check_val("arst_flags", 32'({bus_if.gt, bus_if.eq, bus_if.lt}), 32'd0);
      check_val("arst_slices", 32'(bus_if.slices), 32'd0);
      $display("txn async reset during COMPARE");
      @(negedge clk);
      rst_n = 1'b1;
      do_cmp("after_rst", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 3'b100, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gt_compare_sequencer.md
# gt_compare_sequencer

Multi-cycle magnitude-compare controller for the ALU's comparison path. It accepts two WIDTH-bit operands through a valid/ready handshake and evaluates them one 2-bit slice per clock, MSB slice first, using the same 2-bit greater-than primitive as the comparator datapath. It terminates early at the first differing slice and returns a one-hot gt/eq/lt result through a second valid/ready handshake. Unsigned and two's-complement compares are supported per operation.

## Interface

Parameters:
- WIDTH, 32, operand width; must be even and at least 2. Slice count N = WIDTH/2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, rising-edge clock.
  - rst_n, input, 1, asynchronous active-low reset.
- start_valid, input, 1, request carries valid operands.
- start_ready, output, 1, block can accept a request; combinational, high only in IDLE.
- a, input, WIDTH, operand A; captured on accept.
- b, input, WIDTH, operand B; captured on accept.
- is_signed, input, 1, 1 selects a two's-complement compare; captured on accept.
- res_valid, output, 1, result is valid; registered.
- res_ready, input, 1, consumer accepts the result.
- gt, output, 1, A > B; registered.
- eq, output, 1, A == B; registered.
- lt, output, 1, A < B; registered.
- slices, output, clog2(N+1), number of slices examined; registered.
- busy, output, 1, high in COMPARE or DONE.

## Operation

- States: IDLE, COMPARE, DONE.
- **IDLE**
  - start_ready=1.
  - Accept occurs when start_valid && start_ready at a rising edge.
  - On accept: capture a, b and is_signed; set slice index to N-1; clear gt, eq, lt and slices to 0; go to COMPARE.
- **COMPARE**
  - Each edge examines one slice: ap = A[2i+1:2i], bp = B[2i+1:2i].
  - Signed mode, top slice only: invert bit 1 of both ap and bp before comparing (offset-binary transform). All other slices compare unsigned.
  - Increment slices on every examined slice.
  - If ap > bp: set gt=1, go to DONE.
  - Else if ap < bp: set lt=1, go to DONE.
  - Else if i == 0: set eq=1, go to DONE.
  - Else decrement i and stay in COMPARE.
- **DONE**
  - res_valid=1; gt, eq, lt and slices are held stable.
  - res_ready high at an edge: go to IDLE and drop res_valid.
  - gt, eq, lt and slices keep their values until the next accept.
- While res_valid=1, exactly one of gt/eq/lt is 1.
- start_valid outside IDLE is ignored, since start_ready=0 there.
- Changes on a, b or is_signed after accept have no effect.

## Timing

- Reset values: state=IDLE; res_valid, gt, eq, lt, slices and busy = 0; start_ready=1.
  - Reset takes effect immediately when rst_n falls, independent of clk.
- Latency: res_valid rises n edges after the accept edge, where n is the number of slices examined (1..N).
  - First slice differs: 1 cycle.
  - Equal operands: N cycles (16 at WIDTH=32).
- Result handover: the DONE-to-IDLE edge consumes the result. start_ready rises in the following cycle.
  - Minimum accept-to-accept spacing is n+2 cycles with res_ready held high.
  - There is no same-cycle restart.
- Backpressure: res_valid and the result stay asserted indefinitely while res_ready=0.
- Reset mid-operation, in COMPARE or DONE: the operation is discarded. There is no res_valid pulse, and outputs return to their reset values.
- res_ready while res_valid=0 has no effect.

## Test plan

- **Reset:** assert rst_n=0 mid-cycle, with no clock edge, during COMPARE.
  - Outputs go to reset values immediately: res_valid=0, gt=eq=lt=0, busy=0, start_ready=1.
  - After release, a new request is accepted normally.
- **Early-exit unsigned:** a=0xFFFFFFFF, b=0x7FFFFFFF, is_signed=0.
  - gt=1, slices=1; res_valid high 1 cycle after accept.
- **Full-length:**
  - a=b=0xA5A5A5A5: eq=1, slices=16, res_valid after 16 cycles.
  - a=0x00000001, b=0x00000002: lt=1, slices=16.
- **Slice sweep:** upper 30 bits equal (0x3FFFFFFF<<2 pattern); bits [1:0] of a and b swept over all 16 combinations.
  - gt = (a[1:0] > b[1:0]); eq and lt match accordingly; one-hot each time; slices=16.
- **Signed:** a=0xFFFFFFFF, b=0x00000001.
  - is_signed=1: lt=1, slices=1.
  - is_signed=0: gt=1, slices=1.
  - a=0x80000000, b=0x7FFFFFFF, is_signed=1: lt=1.
- **Handshake:** hold res_ready=0 for 5 cycles after res_valid.
  - Result and slices stay stable; start_valid pulsed during this time is not accepted (start_ready=0).
  - After res_ready=1, start_ready returns 1 on the next cycle, and the next request is accepted then.
